lsq_unit: RTL and testbench



---
 rtl/lsq_pkg.sv | 46 ++++
 rtl/lsq_load_align.sv | 36 +++
 rtl/lsq_unit.sv | 278 +++++++++++++++++++++++++++
 tb/tb_lsq_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: op codes, lock sentinel rules,
// lsm_bus field geometry and alignment helpers.
package lsq_pkg;

  localparam int OP_W  = 4;
  localparam int OFF_W = 16;

  // Stores occupy the top of the encoding so "op >= OP_SB" identifies them.
  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  // Low address bits cleared to form a word address.
  localparam logic [1:0] ADDR_LO_MASK = 2'b11;

  // lsm_bus layout, MSB to LSB: {op, rd, base_lock, base_data, src_lock, src_data, offset}
  function automatic int lsm_bus_w(input int tag_w, input int data_w);
    return OP_W + 3 * tag_w + 2 * data_w + OFF_W;
  endfunction

  function automatic logic is_store(input op_e op);
    return op >= OP_SB;
  endfunction

  function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsq_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a cache word,
// sign- or zero-extends it, and flags misaligned accesses.
module lsq_load_align
  import lsq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_e               op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    misaligned = is_misaligned(op, addr_lo);
    case (op)
      OP_LB:   result = DATA_W'($signed(byte_sel));
      OP_LBU:  result = DATA_W'(byte_sel);
      OP_LH:   result = DATA_W'($signed(half_sel));
      OP_LHU:  result = DATA_W'(half_sel);
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsq_unit.sv
// lsq_unit: in-order load/store queue with CDB operand snoop, data-cache read
// handshake and a registered CDB result port. LSQ_PREFETCH_EN adds a next-entry prefetch port.
module lsq_unit
  import lsq_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter int  PTR_W   = 3,
  parameter int  NUM_CDB = 2,
  parameter int  DATA_W  = 32,
  parameter int  ADDR_W  = 32,
  parameter int  TAG_W   = 4,
  localparam int LSM_W   = lsm_bus_w(TAG_W, DATA_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      lsm_write,
  input  logic [LSM_W-1:0]          lsm_bus,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_in_index,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_in_data,
  output logic                      buffer_stall,
  input  logic                      rob_stall,
  output logic                      dcache_read,
  output logic [ADDR_W-1:0]         dcache_read_addr,
  input  logic                      dcache_read_done,
  input  logic [DATA_W-1:0]         dcache_read_data,
`ifdef LSQ_PREFETCH_EN
  output logic                      dcache_prefetch,
  output logic [ADDR_W-1:0]         dcache_pre_addr,
`endif
  output logic                      cdb_out_valid,
  output logic [TAG_W-1:0]          cdb_out_index,
  output logic [DATA_W-1:0]         cdb_out_data,
  output logic [ADDR_W-1:0]         cdb_out_addr,
  output logic                      cdb_out_excp
);

  localparam logic [TAG_W-1:0]  NO_LOCK   = '1;
  localparam int                SRCD_LO   = OFF_W;
  localparam int                SRCL_LO   = SRCD_LO + DATA_W;
  localparam int                BASED_LO  = SRCL_LO + TAG_W;
  localparam int                BASEL_LO  = BASED_LO + DATA_W;
  localparam int                RD_LO     = BASEL_LO + TAG_W;
  localparam int                OP_LO     = RD_LO + TAG_W;
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    STALL_C   = DEPTH_C - 1'b1;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(ADDR_LO_MASK);

  // Lowest-numbered port wins: scan high to low so the last hit is the lowest.
  function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0]          lock,
                                                input logic [NUM_CDB*TAG_W-1:0]  idx,
                                                input logic [NUM_CDB*DATA_W-1:0] dat);
    logic [DATA_W:0] hit;
    hit = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (lock != NO_LOCK && idx[p*TAG_W +: TAG_W] == lock) hit = {1'b1, dat[p*DATA_W +: DATA_W]};
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]         valid;
  op_e                      op_q  [DEPTH];
  logic [TAG_W-1:0]         rd_q  [DEPTH];
  logic [TAG_W-1:0]         bl_q  [DEPTH];
  logic [DATA_W-1:0]        bd_q  [DEPTH];
  logic [TAG_W-1:0]         sl_q  [DEPTH];
  logic [DATA_W-1:0]        sd_q  [DEPTH];
  logic signed [OFF_W-1:0]  off_q [DEPTH];
  logic [DATA_W:0]          bl_snp [DEPTH];
  logic [DATA_W:0]          sl_snp [DEPTH];
  logic [DATA_W:0]          in_b_snp, in_s_snp;
  logic [PTR_W-1:0]         wptr, rptr;
  logic [PTR_W:0]           count;
  logic                     full, enq, pop;

  op_e                      in_op;
  logic [TAG_W-1:0]         in_rd, in_bl, in_sl;
  logic [DATA_W-1:0]        in_bd, in_sd;
  logic signed [OFF_W-1:0]  in_off;

  assign in_op  = op_e'(lsm_bus[OP_LO +: OP_W]);
  assign in_rd  = lsm_bus[RD_LO +: TAG_W];
  assign in_bl  = lsm_bus[BASEL_LO +: TAG_W];
  assign in_bd  = lsm_bus[BASED_LO +: DATA_W];
  assign in_sl  = lsm_bus[SRCL_LO +: TAG_W];
  assign in_sd  = lsm_bus[SRCD_LO +: DATA_W];
  assign in_off = lsm_bus[OFF_W-1:0];

  assign full         = (count == DEPTH_C);
  assign enq          = lsm_write && !flush && (!full || pop);
  assign buffer_stall = (count >= STALL_C);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      bl_snp[i] = cdb_match(bl_q[i], cdb_in_index, cdb_in_data);
      sl_snp[i] = cdb_match(sl_q[i], cdb_in_index, cdb_in_data);
    end
    in_b_snp = cdb_match(in_bl, cdb_in_index, cdb_in_data);
    in_s_snp = cdb_match(in_sl, cdb_in_index, cdb_in_data);
  end

  // Queue control: occupancy, pointers, valid bits
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        valid[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      if (enq) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + 1'b1;
      end
      if (enq && !pop)      count <= count + 1'b1;
      else if (pop && !enq) count <= count - 1'b1;
    end
  end

  // Entry payload: snoop capture, then enqueue (with same-cycle bypass) takes priority
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && bl_snp[i][DATA_W]) begin
        bl_q[i] <= NO_LOCK;
        bd_q[i] <= bl_snp[i][DATA_W-1:0];
      end
      if (valid[i] && sl_snp[i][DATA_W]) begin
        sl_q[i] <= NO_LOCK;
        sd_q[i] <= sl_snp[i][DATA_W-1:0];
      end
    end
    if (enq) begin
      op_q[wptr]  <= in_op;
      rd_q[wptr]  <= in_rd;
      off_q[wptr] <= in_off;
      bl_q[wptr]  <= in_b_snp[DATA_W] ? NO_LOCK : in_bl;
      bd_q[wptr]  <= in_b_snp[DATA_W] ? in_b_snp[DATA_W-1:0] : in_bd;
      sl_q[wptr]  <= in_s_snp[DATA_W] ? NO_LOCK : in_sl;
      sd_q[wptr]  <= in_s_snp[DATA_W] ? in_s_snp[DATA_W-1:0] : in_sd;
    end
  end

  logic              head_vld, base_rdy, src_rdy, head_mis, ld_go;
  op_e               head_op;
  logic [ADDR_W-1:0] head_ea;
  logic [DATA_W-1:0] ld_data;

  assign head_vld = valid[rptr];
  assign head_op  = op_q[rptr];
  assign base_rdy = (bl_q[rptr] == NO_LOCK);
  assign src_rdy  = (sl_q[rptr] == NO_LOCK);
  assign head_ea  = ADDR_W'(bd_q[rptr]) + ADDR_W'(off_q[rptr]);
  assign ld_go    = head_vld && base_rdy && !head_mis && !is_store(head_op) && head_op != OP_NOP;

  lsq_load_align #(.DATA_W(DATA_W)) u_align (
    .op         (head_op),
    .addr_lo    (head_ea[1:0]),
    .rdata      (dcache_read_data),
    .result     (ld_data),
    .misaligned (head_mis)
  );

  state_e            state, state_nxt;
  logic              emit, emit_excp, rd_req;
  logic [DATA_W-1:0] emit_data;
  logic [ADDR_W-1:0] emit_addr;

  always_ff @(posedge clk) begin
    if (rst || flush) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (ld_go) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (dcache_read_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    emit      = 1'b0;
    emit_excp = 1'b0;
    emit_data = '0;
    emit_addr = '0;
    rd_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head_vld && base_rdy) begin
          if (head_mis) begin
            emit      = 1'b1;
            emit_excp = 1'b1;
            pop       = 1'b1;
          end else if (is_store(head_op)) begin
            if (src_rdy && !rob_stall) begin
              emit      = 1'b1;
              emit_data = sd_q[rptr];
              emit_addr = head_ea;
              pop       = 1'b1;
            end
          end else if (head_op == OP_NOP) begin
            pop = 1'b1;
          end else begin
            rd_req = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        if (dcache_read_done) begin
          emit      = 1'b1;
          emit_data = ld_data;
          pop       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output register stage: everything seen outside is one cycle after the decision
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_out_valid    <= 1'b0;
      cdb_out_index    <= NO_LOCK;
      cdb_out_data     <= '0;
      cdb_out_addr     <= '0;
      cdb_out_excp     <= 1'b0;
      dcache_read      <= 1'b0;
      dcache_read_addr <= '0;
    end else if (flush) begin
      cdb_out_valid <= 1'b0;
      dcache_read   <= 1'b0;
    end else begin
      cdb_out_valid <= emit;
      dcache_read   <= (state_nxt == ST_RD_WAIT);
      if (emit) begin
        cdb_out_index <= rd_q[rptr];
        cdb_out_data  <= emit_data;
        cdb_out_addr  <= emit_addr;
        cdb_out_excp  <= emit_excp;
      end
      if (rd_req) dcache_read_addr <= head_ea & WORD_MASK;
    end
  end

`ifdef LSQ_PREFETCH_EN
  logic [PTR_W-1:0]  nptr;
  logic [ADDR_W-1:0] next_ea;
  logic [DEPTH-1:0]  pf_sent;
  logic              pf_fire;

  assign nptr    = rptr + 1'b1;
  assign next_ea = ADDR_W'(bd_q[nptr]) + ADDR_W'(off_q[nptr]);
  assign pf_fire = valid[nptr] && (bl_q[nptr] == NO_LOCK) && !pf_sent[nptr] &&
                   !is_misaligned(op_q[nptr], next_ea[1:0]);

  // One prefetch per entry, the first cycle its base is usable at head+1
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pf_sent         <= '0;
      dcache_prefetch <= 1'b0;
      dcache_pre_addr <= '0;
    end else begin
      dcache_prefetch <= pf_fire;
      if (pf_fire) begin
        pf_sent[nptr]   <= 1'b1;
        dcache_pre_addr <= next_ea & WORD_MASK;
      end
      if (enq) pf_sent[wptr] <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lsq_unit.sv
// Self-checking bench for lsq_unit: table of single-instruction vectors plus
// hand sequences for snoop, bypass, fill/wrap and flush; CDB outputs scored from a queue.
module tb_lsq_unit;
  import lsq_pkg::*;

  localparam int LSM_W = 96;
  localparam logic [3:0] NL = 4'hF;

  logic         clk, rst, flush, lsm_write, rob_stall;
  logic [LSM_W-1:0] lsm_bus;
  logic [7:0]   cdb_in_index;
  logic [63:0]  cdb_in_data;
  logic         buffer_stall, dcache_read, dcache_read_done;
  logic [31:0]  dcache_read_addr, dcache_read_data;
  logic         cdb_out_valid, cdb_out_excp;
  logic [3:0]   cdb_out_index;
  logic [31:0]  cdb_out_data, cdb_out_addr;

  lsq_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .lsm_write(lsm_write), .lsm_bus(lsm_bus),
    .cdb_in_index(cdb_in_index), .cdb_in_data(cdb_in_data), .buffer_stall(buffer_stall),
    .rob_stall(rob_stall), .dcache_read(dcache_read), .dcache_read_addr(dcache_read_addr),
    .dcache_read_done(dcache_read_done), .dcache_read_data(dcache_read_data),
    .cdb_out_valid(cdb_out_valid), .cdb_out_index(cdb_out_index), .cdb_out_data(cdb_out_data),
    .cdb_out_addr(cdb_out_addr), .cdb_out_excp(cdb_out_excp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] addr;
    logic        excp;
  } exp_t;

  typedef struct {
    op_e         op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] src;
    logic [31:0] mem;
    logic [3:0]  rd;
    logic [31:0] rdaddr;
    logic [31:0] xdata;
    logic [31:0] xaddr;
    logic        xexcp;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[12];
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk) begin
    if (!rst && cdb_out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out actual idx=%h data=%h addr=%h excp=%b required=no pulse",
                 cdb_out_index, cdb_out_data, cdb_out_addr, cdb_out_excp);
      end else begin
        e = sb.pop_front();
        if (cdb_out_index !== e.idx || cdb_out_data !== e.data ||
            cdb_out_addr !== e.addr || cdb_out_excp !== e.excp) begin
          failures++;
          $display("FAIL cdb_out actual idx=%h data=%h addr=%h excp=%b required idx=%h data=%h addr=%h excp=%b",
                   cdb_out_index, cdb_out_data, cdb_out_addr, cdb_out_excp, e.idx, e.data, e.addr, e.excp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [LSM_W-1:0] mk(input op_e op, input logic [3:0] rd, input logic [3:0] bl,
                                          input logic [31:0] bd, input logic [3:0] sl,
                                          input logic [31:0] sd, input logic [15:0] off);
    return {op, rd, bl, bd, sl, sd, off};
  endfunction

  task automatic enq(input logic [LSM_W-1:0] b);
    lsm_write = 1'b1;
    lsm_bus   = b;
    tick();
    lsm_write = 1'b0;
  endtask

  task automatic wait_read();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dcache_read) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("read_req_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic complete_read(input logic [31:0] data);
    dcache_read_done = 1'b1;
    dcache_read_data = data;
    tick();
    dcache_read_done = 1'b0;
    chk("read_drop_after_done", 32'(dcache_read), 32'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; lsm_write = 1'b0; lsm_bus = '0; rob_stall = 1'b0;
    cdb_in_index = {NL, NL}; cdb_in_data = '0;
    dcache_read_done = 1'b0; dcache_read_data = '0;

    tbl[0]  = '{OP_LW,  32'h100,      16'h0004, 32'h0,        32'hDEADBEEF, 4'd1,  32'h104,  32'hDEADBEEF, 32'h0,   1'b0};
    tbl[1]  = '{OP_LB,  32'h100,      16'h0003, 32'h0,        32'h80112233, 4'd2,  32'h100,  32'hFFFFFF80, 32'h0,   1'b0};
    tbl[2]  = '{OP_LBU, 32'h100,      16'h0003, 32'h0,        32'h80112233, 4'd3,  32'h100,  32'h00000080, 32'h0,   1'b0};
    tbl[3]  = '{OP_LHU, 32'h100,      16'h0002, 32'h0,        32'h80112233, 4'd4,  32'h100,  32'h00008011, 32'h0,   1'b0};
    tbl[4]  = '{OP_LH,  32'h102,      16'hFFFE, 32'h0,        32'h80112233, 4'd5,  32'h100,  32'h00002233, 32'h0,   1'b0};
    tbl[5]  = '{OP_LB,  32'h100,      16'h0001, 32'h0,        32'h80112233, 4'd6,  32'h100,  32'h00000022, 32'h0,   1'b0};
    tbl[6]  = '{OP_LH,  32'h101,      16'h0000, 32'h0,        32'h0,        4'd7,  32'h0,    32'h0,        32'h0,   1'b1};
    tbl[7]  = '{OP_SW,  32'h200,      16'h0008, 32'h12345678, 32'h0,        4'd8,  32'h0,    32'h12345678, 32'h208, 1'b0};
    tbl[8]  = '{OP_SB,  32'h200,      16'h0003, 32'h000000AB, 32'h0,        4'd9,  32'h0,    32'h000000AB, 32'h203, 1'b0};
    tbl[9]  = '{OP_SW,  32'h202,      16'h0000, 32'h11111111, 32'h0,        4'd10, 32'h0,    32'h0,        32'h0,   1'b1};
    tbl[10] = '{OP_LW,  32'hFFFFFFFC, 16'h0008, 32'h0,        32'h11223344, 4'd11, 32'h4,    32'h11223344, 32'h0,   1'b0};
    tbl[11] = '{OP_LHU, 32'h10,       16'h7FFE, 32'h0,        32'hF00D1234, 4'd12, 32'h800C, 32'h0000F00D, 32'h0,   1'b0};

    repeat (3) tick();
    chk("rst_valid", 32'(cdb_out_valid), 32'd0);
    chk("rst_index", 32'(cdb_out_index), 32'hF);
    chk("rst_data", cdb_out_data, 32'h0);
    chk("rst_addr", cdb_out_addr, 32'h0);
    chk("rst_excp", 32'(cdb_out_excp), 32'd0);
    chk("rst_dread", 32'(dcache_read), 32'd0);
    chk("rst_daddr", dcache_read_addr, 32'h0);
    chk("rst_stall", 32'(buffer_stall), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      sb.push_back('{tbl[i].rd, tbl[i].xdata, tbl[i].xaddr, tbl[i].xexcp});
      enq(mk(tbl[i].op, tbl[i].rd, NL, tbl[i].base, NL, tbl[i].src, tbl[i].off));
      if (!is_store(tbl[i].op) && !tbl[i].xexcp) begin
        wait_read();
        for (int k = 0; k < 3; k++) begin
          chk("read_addr_hold", dcache_read_addr, tbl[i].rdaddr);
          chk("read_req_hold", 32'(dcache_read), 32'd1);
          tick();
        end
        complete_read(tbl[i].mem);
      end else begin
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
          seen = seen | dcache_read;
          tick();
        end
        chk("no_cache_read", 32'(seen), 32'd0);
      end
      wait_drain();
    end

    // store waits on src tag 5 and on rob_stall
    rob_stall = 1'b1;
    sb.push_back('{4'd7, 32'h55, 32'h300, 1'b0});
    enq(mk(OP_SW, 4'd7, NL, 32'h300, 4'd5, 32'h0, 16'h0));
    repeat (3) tick();
    chk("store_held_src", 32'(sb.size()), 32'd1);
    cdb_in_index = {4'd5, NL}; cdb_in_data = {32'h55, 32'h0};
    tick();
    cdb_in_index = {NL, NL}; cdb_in_data = '0;
    repeat (3) tick();
    chk("store_held_rob", 32'(sb.size()), 32'd1);
    rob_stall = 1'b0;
    wait_drain();

    // same tag on both ports: port 0 data must win
    sb.push_back('{4'd8, 32'h77, 32'h400, 1'b0});
    enq(mk(OP_SW, 4'd8, 4'd3, 32'h0, NL, 32'h77, 16'h0));
    cdb_in_index = {4'd3, 4'd3}; cdb_in_data = {32'h500, 32'h400};
    tick();
    cdb_in_index = {NL, NL}; cdb_in_data = '0;
    wait_drain();

    // base tag broadcast in the enqueue cycle is bypassed into the entry
    sb.push_back('{4'd3, 32'h1234, 32'h0, 1'b0});
    cdb_in_index = {NL, 4'd2}; cdb_in_data = {32'h0, 32'h500};
    enq(mk(OP_LW, 4'd3, 4'd2, 32'h0, NL, 32'h0, 16'h4));
    cdb_in_index = {NL, NL}; cdb_in_data = '0;
    wait_read();
    chk("bypass_addr", dcache_read_addr, 32'h504);
    complete_read(32'h1234);
    wait_drain();

    // three fills; the ninth write is dropped, last fill enqueues while full and popping
    for (int f = 0; f < 3; f++) begin
      rob_stall = 1'b1;
      for (int k = 0; k < 9; k++) begin
        if (k < 8) sb.push_back('{4'(k), 32'h1000 + 32'(f * 16 + k), 32'h800 + 32'(4 * k), 1'b0});
        enq(mk(OP_SW, 4'(k), NL, 32'h800, NL, 32'h1000 + 32'(f * 16 + k), 16'(4 * k)));
        if (k == 5) chk("stall_below", 32'(buffer_stall), 32'd0);
        if (k == 6) chk("stall_at_depth_m1", 32'(buffer_stall), 32'd1);
      end
      chk("full_held", 32'(sb.size()), 32'd8);
      if (f == 2) begin
        sb.push_back('{4'd9, 32'h9999, 32'h900, 1'b0});
        rob_stall = 1'b0;
        enq(mk(OP_SW, 4'd9, NL, 32'h900, NL, 32'h9999, 16'h0));
      end else begin
        rob_stall = 1'b0;
        tick();
      end
      wait_drain();
    end

    // flush in RD_WAIT discards the load and the queued store; late done is ignored
    enq(mk(OP_LW, 4'd10, NL, 32'h600, NL, 32'h0, 16'h0));
    enq(mk(OP_SW, 4'd11, NL, 32'h700, NL, 32'hAAAA, 16'h0));
    wait_read();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_drops_read", 32'(dcache_read), 32'd0);
    tick();
    dcache_read_done = 1'b1; dcache_read_data = 32'hBAD0BAD0;
    tick();
    dcache_read_done = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | dcache_read;
      tick();
    end
    chk("flush_no_read", 32'(seen), 32'd0);
    chk("flush_stall", 32'(buffer_stall), 32'd0);
    sb.push_back('{4'd12, 32'hCAFE0000, 32'h0, 1'b0});
    enq(mk(OP_LW, 4'd12, NL, 32'h40, NL, 32'h0, 16'h0));
    wait_read();
    chk("post_flush_addr", dcache_read_addr, 32'h40);
    complete_read(32'hCAFE0000);
    wait_drain();

    repeat (4) tick();
    chk("final_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
